pipe_reg_file: RTL

//  Parametrised register file for the pipelined datapath: two combinational read

---
 rtl/pipe_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 41 ++++
 rtl/pipe_reg_file.sv | 88 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipelined datapath register file.
package pipe_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    // True when the address hits a hardwired-zero R0.
    function automatic logic is_zero_reg(input logic zero_en, input reg_addr_t addr);
        return zero_en && (addr == '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector for RAW hazard detection plus the sticky
// "write to an unclaimed register" flag.
module rf_scoreboard #(
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  wr_ok,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  claim_ok,
    input  logic [ADDR_W-1:0]     claim_addr,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic                  wr_unclaimed
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_next;
    logic             unclaimed_next;

    // Writeback clears, claim sets; a same-register claim wins over the clear.
    always_comb begin
        busy_next = busy;
        if (wr_ok)
            busy_next[wr_addr] = 1'b0;
        if (claim_ok)
            busy_next[claim_addr] = 1'b1;
        unclaimed_next = wr_unclaimed | (wr_ok & ~busy[wr_addr]);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            busy         <= '0;
            wr_unclaimed <= 1'b0;
        end else begin
            busy         <= busy_next;
            wr_unclaimed <= unclaimed_next;
        end
    end

endmodule

// File: rtl/pipe_reg_file.sv
// Register file: two combinational read ports, one writeback port, optional
// write-to-read bypass and hardwired-zero R0, with a busy scoreboard.
module pipe_reg_file
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              hazard_a,
    output logic              hazard_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              wr_unclaimed
);

    localparam int   DEPTH   = 1 << ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;
    logic              claim_ok;
    logic              zero_a;
    logic              zero_b;
    logic              fwd_a;
    logic              fwd_b;

    assign wr_ok    = wr_en & ~(ZERO_EN && (wr_addr == '0));
    assign claim_ok = claim_en & ~(ZERO_EN && (claim_addr == '0));
    assign zero_a   = ZERO_EN && (rd_addr_a == '0);
    assign zero_b   = ZERO_EN && (rd_addr_b == '0);
    assign fwd_a    = BYP_EN & wr_ok & (wr_addr == rd_addr_a);
    assign fwd_b    = BYP_EN & wr_ok & (wr_addr == rd_addr_b);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Outputs are forced quiet while Reset is held so bypassed data cannot leak.
    always_comb begin
        rd_data_a = '0;
        hazard_a  = 1'b0;
        if (Reset && !zero_a) begin
            rd_data_a = fwd_a ? wr_data : regs[rd_addr_a];
            hazard_a  = busy[rd_addr_a] & ~fwd_a;
        end
    end

    always_comb begin
        rd_data_b = '0;
        hazard_b  = 1'b0;
        if (Reset && !zero_b) begin
            rd_data_b = fwd_b ? wr_data : regs[rd_addr_b];
            hazard_b  = busy[rd_addr_b] & ~fwd_b;
        end
    end

    rf_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .Reset       (Reset),
        .wr_ok       (wr_ok),
        .wr_addr     (wr_addr),
        .claim_ok    (claim_ok),
        .claim_addr  (claim_addr),
        .busy        (busy),
        .wr_unclaimed(wr_unclaimed)
    );

endmodule
